// File: rtl/divider_controller.sv
// Sequencer for a 12b/6b restoring divider. Loads A, Q and the counter, then
// runs six shift/subtract/restore iterations and signals done. Requests with a
// zero divisor, or whose quotient would not fit in 6 bits, are rejected up
// front with err, so the datapath is never started for them.
module divider_controller #(
   parameter logic CHECK_OVF = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [11:0] dividend_i,
   input  logic [5:0]  divisor_i,
   input  logic        sign_A_i,
   input  logic        co_i,
   output logic        en_o,
   output logic        ld_A_o,
   output logic        sh_A_o,
   output logic        ld_Q_o,
   output logic        sh_Q_o,
   output logic        set_Q0_o,
   output logic        sel_D_o,
   output logic        sel_A_o,
   output logic        ld_cnt_o,
   output logic        en_cnt_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_INIT    = 4'd1;
   localparam logic [3:0] S_SHIFT   = 4'd2;
   localparam logic [3:0] S_SUB     = 4'd3;
   localparam logic [3:0] S_CHECK   = 4'd4;
   localparam logic [3:0] S_RESTORE = 4'd5;
   localparam logic [3:0] S_SETQ    = 4'd6;
   localparam logic [3:0] S_NEXT    = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;

   logic [3:0] state_q, state_d;
   logic       err_q, err_d;
   logic       bad_req;

   // A zero divisor always fails; a high half >= divisor would need a 7-bit
   // quotient, so it is rejected unless the check is compiled out.
   assign bad_req = (divisor_i == 6'd0) |
                    (CHECK_OVF & (dividend_i[11:6] >= divisor_i));

   // State and error-flag registers; reset aborts any run in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; unused encodings fall back to IDLE.
   always_comb begin
      state_d = S_IDLE;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
            if (start_i) begin
               if (bad_req) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_INIT;
                  err_d   = 1'b0;
               end
            end
         end
         S_INIT:    state_d = S_SHIFT;
         S_SHIFT:   state_d = S_SUB;
         S_SUB:     state_d = S_CHECK;
         S_CHECK:   state_d = sign_A_i ? S_RESTORE : S_SETQ;
         S_RESTORE: state_d = S_NEXT;
         S_SETQ:    state_d = S_NEXT;
         S_NEXT:    state_d = co_i ? S_DONE : S_SHIFT;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Control strobes decoded from the current state; anything not named is 0.
   always_comb begin
      en_o     = 1'b0;
      ld_A_o   = 1'b0;
      sh_A_o   = 1'b0;
      ld_Q_o   = 1'b0;
      sh_Q_o   = 1'b0;
      set_Q0_o = 1'b0;
      sel_D_o  = 1'b0;
      sel_A_o  = 1'b0;
      ld_cnt_o = 1'b0;
      en_cnt_o = 1'b0;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      err_o    = 1'b0;
      case (state_q)
         S_INIT: begin
            sel_A_o  = 1'b1;
            ld_A_o   = 1'b1;
            ld_Q_o   = 1'b1;
            ld_cnt_o = 1'b1;
            busy_o   = 1'b1;
         end
         S_SHIFT: begin
            sh_A_o = 1'b1;
            sh_Q_o = 1'b1;
            busy_o = 1'b1;
         end
         S_SUB: begin
            en_o   = 1'b1;
            ld_A_o = 1'b1;
            busy_o = 1'b1;
         end
         S_CHECK: busy_o = 1'b1;
         S_RESTORE: begin
            en_o    = 1'b1;
            sel_D_o = 1'b1;
            ld_A_o  = 1'b1;
            busy_o  = 1'b1;
         end
         S_SETQ: begin
            set_Q0_o = 1'b1;
            busy_o   = 1'b1;
         end
         S_NEXT: begin
            // Counter only advances when another iteration follows.
            en_cnt_o = ~co_i;
            busy_o   = 1'b1;
         end
         S_DONE: begin
            done_o = 1'b1;
            err_o  = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_divider_controller.sv
// Bench for divider_controller: two controllers (overflow check on and off)
// each drive a small behavioural datapath. Expected results come from plain
// integer division and are queued at issue; a monitor checks each done pulse.
module tb_divider_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] dividend = '0;
   logic [5:0]  divisor = '0;

   logic [1:0] en, ld_A, sh_A, ld_Q, sh_Q, set_Q0, sel_D, sel_A;
   logic [1:0] ld_cnt, en_cnt, busy, done, err, sign_A, co;
   logic [5:0] qv [2];
   logic [5:0] rv [2];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [6:0] A_q;
      logic [5:0] Q_q;
      logic [2:0] cnt_q;

      divider_controller #(.CHECK_OVF(g == 0 ? 1'b1 : 1'b0)) u_dut (
         .clk(clk), .rst(rst), .start_i(start), .dividend_i(dividend),
         .divisor_i(divisor), .sign_A_i(sign_A[g]), .co_i(co[g]),
         .en_o(en[g]), .ld_A_o(ld_A[g]), .sh_A_o(sh_A[g]), .ld_Q_o(ld_Q[g]),
         .sh_Q_o(sh_Q[g]), .set_Q0_o(set_Q0[g]), .sel_D_o(sel_D[g]),
         .sel_A_o(sel_A[g]), .ld_cnt_o(ld_cnt[g]), .en_cnt_o(en_cnt[g]),
         .busy_o(busy[g]), .done_o(done[g]), .err_o(err[g])
      );

      // Datapath registers are not reset, matching the real datapath.
      always @(posedge clk) begin
         if (ld_A[g])
            A_q <= sel_A[g] ? {1'b0, dividend[11:6]}
                 : (sel_D[g] ? A_q + {1'b0, divisor} : A_q - {1'b0, divisor});
         else if (sh_A[g])
            A_q <= {A_q[5:0], Q_q[5]};
         if (ld_Q[g])        Q_q <= dividend[5:0];
         else if (sh_Q[g])   Q_q <= {Q_q[4:0], 1'b0};
         else if (set_Q0[g]) Q_q[0] <= 1'b1;
         if (ld_cnt[g])      cnt_q <= 3'd2;
         else if (en_cnt[g]) cnt_q <= cnt_q + 3'd1;
      end
      assign sign_A[g] = A_q[6];
      assign co[g]     = (cnt_q == 3'd7) & ~ld_cnt[g];
      assign qv[g]     = Q_q;
      assign rv[g]     = A_q[5:0];
   end

   typedef struct {
      int         done_cyc;
      bit         err;
      bit         chk_qr;
      int         busy_n;
      logic [5:0] q;
      logic [5:0] r;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   total = 0;
   int   bad = 0;
   int   bcnt [2] = '{0, 0};

   task automatic chk(input string nm, input bit ok, input int act, input int exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   // Reference: integer division plus the rejection rules.
   function automatic void push(input int i, input logic [11:0] dvd,
                                input logic [5:0] dvs, input int issue);
      exp_t e;
      bit   ovf = (dvs != 0) && (dvd[11:6] >= dvs);
      e.err      = (dvs == 0) || (i == 0 && ovf);
      e.chk_qr   = !e.err && !ovf;
      e.done_cyc = issue + (e.err ? 1 : 32);
      e.busy_n   = e.err ? 0 : 31;
      e.q        = (dvs == 0) ? 6'd0 : 6'(int'(dvd) / int'(dvs));
      e.r        = (dvs == 0) ? 6'd0 : 6'(int'(dvd) % int'(dvs));
      if (i == 0) q0.push_back(e); else q1.push_back(e);
   endfunction

   // Monitor: strobe exclusivity every cycle, result check on each done.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            exp_t e;
            chk($sformatf("cnt_excl%0d", i), !(ld_cnt[i] && en_cnt[i]), 1, 0);
            chk($sformatf("A_excl%0d", i), !(ld_A[i] && sh_A[i]), 1, 0);
            chk($sformatf("Q_excl%0d", i),
                $onehot0({ld_Q[i], sh_Q[i], set_Q0[i]}), 1, 0);
            if (qsize(i) > 0) begin
               e = (i == 0) ? q0[0] : q1[0];
               if (e.err)
                  chk($sformatf("err_run_load%0d", i),
                      !(ld_A[i] || ld_Q[i] || ld_cnt[i]), 1, 0);
            end
            if (busy[i]) bcnt[i]++;
            if (done[i]) begin
               if (qsize(i) == 0) begin
                  chk($sformatf("spurious_done%0d", i), 1'b0, 1, 0);
               end else begin
                  e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("done_cycle%0d", i), cyc == e.done_cyc, cyc, e.done_cyc);
                  chk($sformatf("err%0d", i), err[i] == e.err, int'(err[i]), int'(e.err));
                  chk($sformatf("busy_len%0d", i), bcnt[i] == e.busy_n, bcnt[i], e.busy_n);
                  if (e.chk_qr) begin
                     chk($sformatf("quot%0d", i), qv[i] == e.q, int'(qv[i]), int'(e.q));
                     chk($sformatf("rem%0d", i), rv[i] == e.r, int'(rv[i]), int'(e.r));
                  end
               end
               bcnt[i] = 0;
            end
         end
      end
   end

   task automatic wait_empty();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         chk("completion_timeout", 1'b0, n, 200);
         q0.delete();
         q1.delete();
      end
   endtask

   task automatic issue(input logic [11:0] dvd, input logic [5:0] dvs, output int at);
      @(negedge clk); #1;
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      at       = cyc;
      push(0, dvd, dvs, at);
      push(1, dvd, dvs, at);
   endtask

   // One transaction; optional start noise while both controllers are busy.
   task automatic run_one(input logic [11:0] dvd, input logic [5:0] dvs, input bit noise);
      int at;
      issue(dvd, dvs, at);
      @(negedge clk); #1;
      start = 1'b0;
      if (noise) begin
         repeat (29) begin
            @(negedge clk); #1;
            start = 1'($urandom % 2);
         end
         start = 1'b0;
      end
      wait_empty();
   endtask

   task automatic check_all_zero(input string nm);
      logic [25:0] outs;
      outs = {en, ld_A, sh_A, ld_Q, sh_Q, set_Q0, sel_D, sel_A, ld_cnt,
              en_cnt, busy, done, err};
      chk(nm, outs == '0, int'(outs), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int at;
      logic [11:0] dvd;
      logic [5:0]  dvs;
      #1;
      check_all_zero("reset_outputs");
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      run_one(12'd45, 6'd7, 1'b0);
      run_one(12'd63, 6'd1, 1'b0);
      run_one(12'h0FF, 6'd9, 1'b0);
      run_one(12'd45, 6'd0, 1'b0);
      run_one(12'hFFF, 6'd0, 1'b0);
      run_one(12'h1C0, 6'd7, 1'b0);
      run_one(12'hFFF, 6'd63, 1'b0);
      run_one(12'hF80, 6'd63, 1'b0);
      run_one(12'd0, 6'd5, 1'b0);
      run_one(12'd45, 6'd7, 1'b1);

      // Reset during SUB of the third iteration, then a clean rerun.
      issue(12'd45, 6'd7, at);
      @(negedge clk); #1;
      start = 1'b0;
      while (cyc < at + 13) begin
         @(negedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check_all_zero("reset_midrun");
      q0.delete();
      q1.delete();
      bcnt[0] = 0;
      bcnt[1] = 0;
      @(negedge clk); #1;
      rst = 1'b0;
      run_one(12'd45, 6'd7, 1'b0);

      // Start held high: one accepted request every 33 cycles.
      issue(12'h0FF, 6'd9, at);
      for (int k = 1; k < 3; k++) begin
         push(0, 12'h0FF, 6'd9, at + 33 * k);
         push(1, 12'h0FF, 6'd9, at + 33 * k);
      end
      while (cyc < at + 70) begin
         @(negedge clk); #1;
      end
      start = 1'b0;
      wait_empty();

      // Randomized requests, mostly legal, some rejected.
      for (int t = 0; t < 24; t++) begin
         dvs = ($urandom % 10 == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         if (dvs == 0 || $urandom % 4 == 0)
            dvd = 12'($urandom);
         else
            dvd = {6'($urandom_range(0, int'(dvs) - 1)), 6'($urandom)};
         run_one(dvd, dvs, (dvs != 0) && (dvd[11:6] < dvs) && ($urandom % 2 == 1));
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
